// File: rtl/fb_trip_ctrl_if.sv
// Signal bundle between the feedback trip controller and its driver/readback side.
interface fb_trip_ctrl_if #(
  parameter int CNT_W  = 8,
  parameter int TRIP_W = 16
);
  logic              arm;
  logic              store_strb;
  logic              oflow;
  logic [CNT_W-1:0]  oflow_limit;
  logic [CNT_W-1:0]  holdoff_trains;
  logic              auto_rearm;
  logic              clr_trip;
  logic              fb_en;
  logic              tripped;
  logic [2:0]        state;
  logic [CNT_W-1:0]  oflow_cnt;
  logic [TRIP_W-1:0] trip_count;
  logic [15:0]       trip_pos;

  modport master (
    output arm, store_strb, oflow, oflow_limit, holdoff_trains, auto_rearm, clr_trip,
    input  fb_en, tripped, state, oflow_cnt, trip_count, trip_pos
  );

  modport slave (
    input  arm, store_strb, oflow, oflow_limit, holdoff_trains, auto_rearm, clr_trip,
    output fb_en, tripped, state, oflow_cnt, trip_count, trip_pos
  );
endinterface

// File: rtl/fb_trip_ctrl.sv
// Feedback enable sequencing and overflow trip protection, one decision per pulse train.
// Define FB_TRIP_TIMESTAMP_EN to build the in-train trip position capture (trip_pos).
//
// state   | meaning
// IDLE    | feedback not requested (arm=0)
// WAIT    | armed, waiting for the current train to end
// ARMED   | waiting for the next train rise
// ACTIVE  | feedback enabled for this train, overflows counted
// TRIPPED | overflow limit hit, feedback held off
// HOLDOFF | skipping trains before automatic re-arm
module fb_trip_ctrl #(
  parameter int CNT_W  = 8,
  parameter int TRIP_W = 16
) (
  input logic          clk,
  input logic          rst,
  fb_trip_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_ARMED   = 3'd2,
    S_ACTIVE  = 3'd3,
    S_TRIPPED = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  state_t            state_q, state_n;
  logic              prev_q;
  logic              rise, fall;
  logic [CNT_W-1:0]  oflow_cnt_q, oflow_cnt_n;
  logic [CNT_W-1:0]  hold_q, hold_n;
  logic [TRIP_W-1:0] trip_count_q;
  logic              tripped_q, tripped_n;
  logic              fb_en_q;
  logic [CNT_W:0]    oflow_sum;
  logic              trip_hit;

  assign rise      = bus.store_strb & ~prev_q;
  assign fall      = ~bus.store_strb & prev_q;
  assign oflow_sum = {1'b0, oflow_cnt_q} + {{CNT_W{1'b0}}, bus.oflow};

  // arm=0 and clr_trip both outrank a trip on the same edge
  assign trip_hit = bus.arm && !bus.clr_trip && (state_q == S_ACTIVE) &&
                    (bus.oflow_limit != '0) && (oflow_sum >= {1'b0, bus.oflow_limit});

  always_comb begin
    state_n     = state_q;
    tripped_n   = tripped_q;
    hold_n      = hold_q;
    oflow_cnt_n = oflow_cnt_q;
    if (!bus.arm) begin
      state_n = S_IDLE;
    end else begin
      if (bus.clr_trip) tripped_n = 1'b0;
      case (state_q)
        S_IDLE:  state_n = S_WAIT;
        S_WAIT:  if (!bus.store_strb) state_n = S_ARMED;
        S_ARMED: begin
          if (rise) begin
            state_n     = S_ACTIVE;
            oflow_cnt_n = '0;
          end
        end
        S_ACTIVE: begin
          if (bus.oflow && (oflow_cnt_q != '1)) oflow_cnt_n = oflow_cnt_q + 1'b1;
          if (trip_hit) begin
            state_n   = S_TRIPPED;
            tripped_n = 1'b1;
          end else if (fall) begin
            state_n = S_ARMED;
          end
        end
        S_TRIPPED: begin
          if (bus.clr_trip) begin
            state_n = S_WAIT;
          end else if (bus.auto_rearm) begin
            state_n = S_HOLDOFF;
            hold_n  = '0;
          end
        end
        S_HOLDOFF: begin
          if (bus.clr_trip || (hold_q == bus.holdoff_trains)) state_n = S_WAIT;
          else if (fall) hold_n = hold_q + 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      prev_q       <= 1'b0;
      oflow_cnt_q  <= '0;
      hold_q       <= '0;
      tripped_q    <= 1'b0;
      fb_en_q      <= 1'b0;
      trip_count_q <= '0;
    end else begin
      state_q     <= state_n;
      prev_q      <= bus.store_strb;
      oflow_cnt_q <= oflow_cnt_n;
      hold_q      <= hold_n;
      tripped_q   <= tripped_n;
      fb_en_q     <= (state_n == S_ACTIVE);
      if (trip_hit && (trip_count_q != '1)) trip_count_q <= trip_count_q + 1'b1;
    end
  end

`ifdef FB_TRIP_TIMESTAMP_EN
  logic [15:0] ts_q, pos_q, pos_cur;

  // ts_q trails the current train offset by one cycle; the rise cycle is offset 0
  assign pos_cur = (ts_q == 16'hFFFF) ? ts_q : ts_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q  <= '0;
      pos_q <= '0;
    end else begin
      if (rise) ts_q <= '0;
      else if (state_q == S_ACTIVE) ts_q <= pos_cur;
      if (trip_hit) pos_q <= pos_cur;
    end
  end

  assign bus.trip_pos = pos_q;
`else
  assign bus.trip_pos = '0;
`endif

  assign bus.fb_en      = fb_en_q;
  assign bus.tripped    = tripped_q;
  assign bus.state      = state_q;
  assign bus.oflow_cnt  = oflow_cnt_q;
  assign bus.trip_count = trip_count_q;

endmodule

// File: tb/tb_fb_trip_ctrl.sv
// Directed bench for fb_trip_ctrl: train framing, trips, manual/auto re-arm, arm control, reset.
module tb_fb_trip_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

`ifdef FB_TRIP_TIMESTAMP_EN
  localparam int POS_A = 30;
  localparam int POS_B = 40;
`else
  localparam int POS_A = 0;
  localparam int POS_B = 0;
`endif

  fb_trip_ctrl_if #(.CNT_W(8), .TRIP_W(16)) bus ();

  fb_trip_ctrl #(.CNT_W(8), .TRIP_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one train of len high cycles plus gap low cycles; oflow at the listed offsets.
  task automatic train(input int len, input int gap, input int p0, input int p1,
                       input int p2, output int fb_cnt);
    fb_cnt = 0;
    for (int i = 0; i < len + gap; i++) begin
      bus.store_strb = (i < len);
      bus.oflow      = (i == p0) || (i == p1) || (i == p2);
      step();
      if (bus.fb_en) fb_cnt++;
    end
    bus.oflow = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.arm = 1'b1;
    step();
    step();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++; if (bus.fb_en !== 1'b0) begin errors++; $display("FAIL reset_fb_en got=%0b exp=0", bus.fb_en); end
    checks++; if (bus.tripped !== 1'b0) begin errors++; $display("FAIL reset_tripped got=%0b exp=0", bus.tripped); end
    checks++; if (bus.oflow_cnt !== 8'd0) begin errors++; $display("FAIL reset_oflow_cnt got=%0d exp=0", bus.oflow_cnt); end
    checks++; if (bus.trip_count !== 16'd0) begin errors++; $display("FAIL reset_trip_count got=%0d exp=0", bus.trip_count); end
    checks++; if (bus.trip_pos !== 16'd0) begin errors++; $display("FAIL reset_trip_pos got=%0d exp=0", bus.trip_pos); end
    rst = 1'b0;
    bus.arm = 1'b0;
    step();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL idle_state got=%0d exp=0", bus.state); end
  endtask

  task automatic test_normal_train();
    int cnt = 0;
    bus.oflow_limit = 8'd4;
    bus.arm = 1'b1;
    step();
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL arm_wait got=%0d exp=1", bus.state); end
    step();
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL arm_armed got=%0d exp=2", bus.state); end
    for (int i = 0; i < 200; i++) begin
      bus.store_strb = 1'b1;
      checks++; if (i == 0 && bus.fb_en !== 1'b0) begin errors++; $display("FAIL normal_pre_rise got=%0b exp=0", bus.fb_en); end
      step();
      if (bus.fb_en) cnt++;
    end
    bus.store_strb = 1'b0;
    step();
    checks++; if (bus.fb_en !== 1'b0) begin errors++; $display("FAIL normal_fb_after_fall got=%0b exp=0", bus.fb_en); end
    checks++; if (cnt !== 200) begin errors++; $display("FAIL normal_fb_cycles got=%0d exp=200", cnt); end
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL normal_end_state got=%0d exp=2", bus.state); end
    checks++; if (bus.trip_count !== 16'd0) begin errors++; $display("FAIL normal_trip_count got=%0d exp=0", bus.trip_count); end
    repeat (5) step();
  endtask

  task automatic test_trip();
    int cnt;
    bus.oflow_limit = 8'd3;
    train(50, 10, 10, 20, 30, cnt);
    checks++; if (cnt !== 30) begin errors++; $display("FAIL trip_fb_cycles got=%0d exp=30", cnt); end
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL trip_state got=%0d exp=4", bus.state); end
    checks++; if (bus.tripped !== 1'b1) begin errors++; $display("FAIL trip_flag got=%0b exp=1", bus.tripped); end
    checks++; if (bus.trip_count !== 16'd1) begin errors++; $display("FAIL trip_count got=%0d exp=1", bus.trip_count); end
    checks++; if (bus.oflow_cnt !== 8'd3) begin errors++; $display("FAIL trip_oflow_cnt got=%0d exp=3", bus.oflow_cnt); end
    checks++; if (bus.trip_pos !== 16'(POS_A)) begin errors++; $display("FAIL trip_pos got=%0d exp=%0d", bus.trip_pos, POS_A); end
  endtask

  task automatic test_manual_mode();
    int cnt;
    bus.auto_rearm = 1'b0;
    for (int t = 0; t < 5; t++) begin
      train(20, 10, -1, -1, -1, cnt);
      checks++; if (bus.state !== 3'd4 || cnt !== 0) begin errors++; $display("FAIL manual_hold train=%0d state=%0d fb=%0d exp state=4 fb=0", t, bus.state, cnt); end
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bus.store_strb = 1'b1;
      bus.clr_trip   = (i == 5);
      step();
      if (bus.fb_en) cnt++;
      if (i == 5) begin
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL manual_clr_state got=%0d exp=1", bus.state); end
        checks++; if (bus.tripped !== 1'b0) begin errors++; $display("FAIL manual_clr_flag got=%0b exp=0", bus.tripped); end
      end
    end
    bus.clr_trip = 1'b0;
    checks++; if (cnt !== 0) begin errors++; $display("FAIL manual_no_partial got=%0d exp=0", cnt); end
    bus.store_strb = 1'b0;
    repeat (10) step();
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL manual_rearmed got=%0d exp=2", bus.state); end
    train(20, 10, -1, -1, -1, cnt);
    checks++; if (cnt !== 20) begin errors++; $display("FAIL manual_next_train got=%0d exp=20", cnt); end
  endtask

  task automatic test_limit_zero();
    bus.oflow_limit = 8'd0;
    for (int i = 0; i < 300; i++) begin
      bus.store_strb = 1'b1;
      bus.oflow      = 1'b1;
      step();
    end
    checks++; if (bus.fb_en !== 1'b1 || bus.state !== 3'd3) begin errors++; $display("FAIL limit0_active fb=%0b state=%0d exp fb=1 state=3", bus.fb_en, bus.state); end
    bus.store_strb = 1'b0;
    bus.oflow      = 1'b0;
    repeat (5) step();
    checks++; if (bus.oflow_cnt !== 8'd255) begin errors++; $display("FAIL limit0_sat got=%0d exp=255", bus.oflow_cnt); end
    checks++; if (bus.tripped !== 1'b0) begin errors++; $display("FAIL limit0_tripped got=%0b exp=0", bus.tripped); end
    checks++; if (bus.trip_count !== 16'd1) begin errors++; $display("FAIL limit0_trip_count got=%0d exp=1", bus.trip_count); end
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL limit0_state got=%0d exp=2", bus.state); end
  endtask

  task automatic test_arm_mid_train();
    int cnt = 0;
    bus.oflow_limit = 8'd4;
    for (int i = 0; i < 40; i++) begin
      bus.store_strb = 1'b1;
      bus.arm        = (i != 10);
      step();
      if (i == 10) begin
        checks++; if (bus.state !== 3'd0 || bus.fb_en !== 1'b0) begin errors++; $display("FAIL disarm state=%0d fb=%0b exp state=0 fb=0", bus.state, bus.fb_en); end
      end
      if (i >= 11 && bus.fb_en) cnt++;
    end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL rearm_partial got=%0d exp=0", cnt); end
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL rearm_wait got=%0d exp=1", bus.state); end
    bus.store_strb = 1'b0;
    step();
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL rearm_armed got=%0d exp=2", bus.state); end
    repeat (9) step();
  endtask

  task automatic test_auto_rearm();
    int cnt;
    bus.oflow_limit    = 8'd3;
    bus.holdoff_trains = 8'd2;
    bus.auto_rearm     = 1'b1;
    // trip lands on the same edge as the store_strb fall
    for (int i = 0; i < 50; i++) begin
      bus.store_strb = (i < 40);
      bus.oflow      = (i >= 38) && (i <= 40);
      step();
      if (i == 40) begin
        checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL fall_trip_state got=%0d exp=4", bus.state); end
        checks++; if (bus.fb_en !== 1'b0) begin errors++; $display("FAIL fall_trip_fb got=%0b exp=0", bus.fb_en); end
        checks++; if (bus.trip_count !== 16'd2) begin errors++; $display("FAIL fall_trip_count got=%0d exp=2", bus.trip_count); end
        checks++; if (bus.trip_pos !== 16'(POS_B)) begin errors++; $display("FAIL fall_trip_pos got=%0d exp=%0d", bus.trip_pos, POS_B); end
      end
      if (i == 41) begin
        checks++; if (bus.state !== 3'd5) begin errors++; $display("FAIL holdoff_entry got=%0d exp=5", bus.state); end
      end
    end
    bus.oflow = 1'b0;
    train(20, 10, -1, -1, -1, cnt);
    checks++; if (cnt !== 0 || bus.state !== 3'd5) begin errors++; $display("FAIL holdoff_n1 fb=%0d state=%0d exp fb=0 state=5", cnt, bus.state); end
    train(20, 10, -1, -1, -1, cnt);
    checks++; if (cnt !== 0 || bus.state !== 3'd2) begin errors++; $display("FAIL holdoff_n2 fb=%0d state=%0d exp fb=0 state=2", cnt, bus.state); end
    train(20, 10, -1, -1, -1, cnt);
    checks++; if (cnt !== 20) begin errors++; $display("FAIL holdoff_n3 got=%0d exp=20", cnt); end
    checks++; if (bus.tripped !== 1'b1) begin errors++; $display("FAIL holdoff_sticky got=%0b exp=1", bus.tripped); end
    bus.clr_trip = 1'b1;
    step();
    bus.clr_trip = 1'b0;
    checks++; if (bus.tripped !== 1'b0 || bus.state !== 3'd2) begin errors++; $display("FAIL auto_clr tripped=%0b state=%0d exp 0/2", bus.tripped, bus.state); end
  endtask

  task automatic test_holdoff_one();
    int cnt;
    bus.oflow_limit    = 8'd1;
    bus.holdoff_trains = 8'd1;
    train(30, 10, 5, -1, -1, cnt);
    checks++; if (cnt !== 5) begin errors++; $display("FAIL h1_fb_cycles got=%0d exp=5", cnt); end
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL h1_state got=%0d exp=2", bus.state); end
    checks++; if (bus.trip_count !== 16'd3) begin errors++; $display("FAIL h1_trip_count got=%0d exp=3", bus.trip_count); end
    train(20, 10, -1, -1, -1, cnt);
    checks++; if (cnt !== 20) begin errors++; $display("FAIL h1_next_train got=%0d exp=20", cnt); end
  endtask

  task automatic test_rst_in_holdoff();
    int cnt;
    bus.holdoff_trains = 8'd5;
    train(30, 10, 5, -1, -1, cnt);
    checks++; if (bus.state !== 3'd5) begin errors++; $display("FAIL pre_rst_holdoff got=%0d exp=5", bus.state); end
    rst = 1'b1;
    step();
    checks++; if (bus.state !== 3'd0 || bus.fb_en !== 1'b0 || bus.tripped !== 1'b0) begin
      errors++; $display("FAIL rst_holdoff_ctl state=%0d fb=%0b tripped=%0b exp 0/0/0", bus.state, bus.fb_en, bus.tripped);
    end
    checks++; if (bus.oflow_cnt !== 8'd0 || bus.trip_count !== 16'd0 || bus.trip_pos !== 16'd0) begin
      errors++; $display("FAIL rst_holdoff_cnt oflow_cnt=%0d trip_count=%0d trip_pos=%0d exp 0/0/0", bus.oflow_cnt, bus.trip_count, bus.trip_pos);
    end
    rst = 1'b0;
    bus.arm = 1'b0;
    step();
  endtask

  initial begin
    rst                = 1'b1;
    bus.arm            = 1'b0;
    bus.store_strb     = 1'b0;
    bus.oflow          = 1'b0;
    bus.oflow_limit    = 8'd0;
    bus.holdoff_trains = 8'd0;
    bus.auto_rearm     = 1'b0;
    bus.clr_trip       = 1'b0;
    test_reset();
    test_normal_train();
    test_trip();
    test_manual_mode();
    test_limit_zero();
    test_arm_mid_train();
    test_auto_rearm();
    test_holdoff_one();
    test_rst_in_holdoff();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
